// File: rtl/lbp_pkg.sv
// lbp_pkg: shared constants, state enum and border-address helper for the LBP host memory
package lbp_pkg;
    localparam int ADDR_W = 14;
    localparam int IMG_W  = 128;
    localparam int IMG_N  = IMG_W * IMG_W;
    localparam int COL_W  = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_SERVE,
        S_DONE
    } state_t;

    // True when the address lies on row/col 0 or IMG_W-1.
    function automatic logic is_border(input logic [ADDR_W-1:0] a);
        return (a[COL_W-1:0] == '0) || (a[COL_W-1:0] == COL_W'(IMG_W - 1)) ||
               (a[ADDR_W-1:COL_W] == '0) || (a[ADDR_W-1:COL_W] == (ADDR_W - COL_W)'(IMG_W - 1));
    endfunction
endpackage

// File: rtl/lbp_host_ram.sv
// lbp_host_ram: byte array with one write port, one combinational and one registered read port
//   clk, reset      : clock, sync active-high reset (clears the registered read output only)
//   i_we/i_waddr/i_wdata : write port
//   i_caddr/o_cdata : combinational read port
//   i_raddr/o_rdata : registered read port (returns pre-write data on same-address collision)
module lbp_host_ram #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_caddr,
    output logic [7:0]    o_cdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);
    logic [7:0] r_mem [0:(1<<AW)-1];

    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;

    always_ff @(posedge clk)
        if (reset) o_rdata <= 8'h00;
        else       o_rdata <= r_mem[i_raddr];

    assign o_cdata = r_mem[i_caddr];
endmodule

// File: rtl/lbp_host_mem.sv
// lbp_host_mem: image server and result capture for the LBP engine (optional macro LBP_HOST_CLEAR_EN)
//   load_valid/load_addr/load_data/load_done : image load port
//   gray_ready/gray_req/gray_addr/gray_data  : engine image read port (combinational data)
//   lbp_valid/lbp_addr/lbp_data/finish       : engine result write port
//   rd_addr/rd_data                          : registered result readback
//   done, wr_count, border_err               : status
//   LBP_HOST_CLEAR_EN defined: result store is zeroed between load_done and SERVE
module lbp_host_mem
    import lbp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    input  logic              load_done,
    output logic              gray_ready,
    input  logic              gray_req,
    input  logic [ADDR_W-1:0] gray_addr,
    output logic [7:0]        gray_data,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [7:0]        lbp_data,
    input  logic              finish,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              done,
    output logic [14:0]       wr_count,
    output logic              border_err
);
    state_t            r_state, w_next;
    logic              r_serve_d;
    logic [14:0]       r_wr_count;
    logic              r_border_err;
    logic              w_img_we, w_lbp_we, w_res_we;
    logic [ADDR_W-1:0] w_res_addr;
    logic [7:0]        w_res_data, w_img_cdata, w_img_rdata, w_res_cdata;

    assign w_img_we = load_valid && (r_state == S_IDLE || r_state == S_LOAD);
    assign w_lbp_we = lbp_valid && r_state == S_SERVE;

`ifdef LBP_HOST_CLEAR_EN
    logic [ADDR_W-1:0] r_clr_addr;

    always_ff @(posedge clk)
        if (reset || r_state != S_CLEAR) r_clr_addr <= '0;
        else                             r_clr_addr <= r_clr_addr + 1'b1;

    assign w_res_we   = w_lbp_we || r_state == S_CLEAR;
    assign w_res_addr = (r_state == S_CLEAR) ? r_clr_addr : lbp_addr;
    assign w_res_data = (r_state == S_CLEAR) ? 8'h00 : lbp_data;
`else
    assign w_res_we   = w_lbp_we;
    assign w_res_addr = lbp_addr;
    assign w_res_data = lbp_data;
`endif

    always_ff @(posedge clk)
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (load_valid) w_next = S_LOAD;
`ifdef LBP_HOST_CLEAR_EN
            S_LOAD:  if (load_done) w_next = S_CLEAR;
            S_CLEAR: if (r_clr_addr == ADDR_W'(IMG_N - 1)) w_next = S_SERVE;
`else
            S_LOAD:  if (load_done) w_next = S_SERVE;
            S_CLEAR: w_next = S_SERVE;
`endif
            S_SERVE: if (finish) w_next = S_DONE;
            default: w_next = r_state;
        endcase
    end

    always_ff @(posedge clk)
        if (reset) begin
            r_serve_d    <= 1'b0;
            r_wr_count   <= '0;
            r_border_err <= 1'b0;
        end else begin
            r_serve_d <= r_state == S_SERVE;
            if (w_lbp_we && r_wr_count != 15'h7FFF) r_wr_count <= r_wr_count + 1'b1;
            if (w_lbp_we && is_border(lbp_addr)) r_border_err <= 1'b1;
        end

    lbp_host_ram #(.AW(ADDR_W)) u_img (
        .clk(clk), .reset(reset),
        .i_we(w_img_we), .i_waddr(load_addr), .i_wdata(load_data),
        .i_caddr(gray_addr), .o_cdata(w_img_cdata),
        .i_raddr(gray_addr), .o_rdata(w_img_rdata)
    );

    lbp_host_ram #(.AW(ADDR_W)) u_res (
        .clk(clk), .reset(reset),
        .i_we(w_res_we), .i_waddr(w_res_addr), .i_wdata(w_res_data),
        .i_caddr(rd_addr), .o_cdata(w_res_cdata),
        .i_raddr(rd_addr), .o_rdata(rd_data)
    );

    // Registered SERVE flag delays ready by a cycle; AND with state drops it at once on DONE.
    assign gray_ready = r_serve_d && r_state == S_SERVE;
    assign gray_data  = (gray_req && r_state == S_SERVE) ? w_img_cdata : 8'h00;
    assign done       = r_state == S_DONE;
    assign wr_count   = r_wr_count;
    assign border_err = r_border_err;
endmodule
